approximate_adder_8bit: RTL and testbench

//  8-bit carry-speculative adder with integrated error detection and correction.

---
 rtl/approximate_adder_8bit.sv | 67 ++++++
 tb/tb_approximate_adder_8bit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/approximate_adder_8bit.sv
// 8-bit carry-speculative adder: fast approximate sum, exact corrected sum,
// and a clocked monitor that counts speculation misses.
module approximate_adder_8bit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       A,
  input  logic [7:0]       B,
  input  logic             cin,
  output logic [7:0]       sum,
  output logic             cout,
  output logic [7:0]       approx_sum,
  output logic             approx_cout,
  output logic             spec_err,
  output logic             err_q,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [4:0] nib_add(input logic [3:0] a, input logic [3:0] b,
                                         input logic c);
    return {1'b0, a} + {1'b0, b} + {4'b0000, c};
  endfunction

  logic [4:0]       w_lo;
  logic             w_c4_spec;
  logic [4:0]       w_hi_a;
  logic [4:0]       w_hi;
  logic             w_spec_err;
  logic             r_err_q;
  logic [CNT_W-1:0] r_err_cnt;

  // Speculation uses only bit 3 of each operand; cin never reaches the upper nibble guess.
  assign w_lo       = nib_add(A[3:0], B[3:0], cin);
  assign w_c4_spec  = A[3] & B[3];
  assign w_hi_a     = nib_add(A[7:4], B[7:4], w_c4_spec);
  assign w_hi       = nib_add(A[7:4], B[7:4], w_lo[4]);
  assign w_spec_err = w_lo[4] ^ w_c4_spec;

  assign approx_sum  = {w_hi_a[3:0], w_lo[3:0]};
  assign approx_cout = w_hi_a[4];
  assign sum         = {w_hi[3:0], w_lo[3:0]};
  assign cout        = w_hi[4];
  assign spec_err    = w_spec_err;

  // Miss monitor: registered miss flag and saturating miss counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_q   <= 1'b0;
      r_err_cnt <= {CNT_W{1'b0}};
    end else begin
      r_err_q <= w_spec_err;
      if (w_spec_err && (r_err_cnt != CNT_MAX)) begin
        r_err_cnt <= r_err_cnt + CNT_ONE;
      end else begin
        r_err_cnt <= r_err_cnt;
      end
    end
  end

  assign err_q   = r_err_q;
  assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_approximate_adder_8bit.sv
// Self-checking bench for approximate_adder_8bit: directed table, exhaustive
// sweep, randomized run against an arithmetic model, reset and saturation cases.
module tb_approximate_adder_8bit;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic [7:0]       A;
  logic [7:0]       B;
  logic             cin;
  logic [7:0]       sum;
  logic             cout;
  logic [7:0]       approx_sum;
  logic             approx_cout;
  logic             spec_err;
  logic             err_q;
  logic [CNT_W-1:0] err_cnt;

  int checks = 0;
  int errors = 0;

  logic             exp_q;
  logic [CNT_W-1:0] exp_cnt;

  approximate_adder_8bit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .cin(cin),
    .sum(sum), .cout(cout), .approx_sum(approx_sum), .approx_cout(approx_cout),
    .spec_err(spec_err), .err_q(err_q), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] e_sum;
    logic       e_cout;
    logic [7:0] e_asum;
    logic       e_acout;
    logic       e_err;
  } vec_t;

  vec_t tbl[8];

  // Reference from plain arithmetic: packs {cout,sum,approx_cout,approx_sum,spec_err}.
  function automatic logic [18:0] model(input logic [7:0] a, input logic [7:0] b, input logic c);
    int exact, lo, hi_a, cs, c4;
    logic [8:0] ex9;
    logic [8:0] ap9;
    exact = int'(a) + int'(b) + int'(c);
    lo    = int'(a % 8'd16) + int'(b % 8'd16) + int'(c);
    c4    = lo / 16;
    cs    = (a[3] && b[3]) ? 1 : 0;
    hi_a  = int'(a / 8'd16) + int'(b / 8'd16) + cs;
    ex9   = 9'(exact);
    ap9   = 9'((hi_a * 16) + (lo % 16));
    return {ex9, ap9, (c4 != cs)};
  endfunction

  function automatic logic [18:0] dut_vec();
    return {cout, sum, approx_cout, approx_sum, spec_err};
  endfunction

  task automatic check_comb(input string name, input logic [18:0] exp);
    checks++;
    if (dut_vec() !== exp) begin
      errors++;
      $display("FAIL %s A=%h B=%h cin=%b got=%h want=%h", name, A, B, cin, dut_vec(), exp);
    end
  endtask

  task automatic check_seq(input string name);
    checks++;
    if (err_q !== exp_q || err_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL %s got err_q=%b err_cnt=%h want err_q=%b err_cnt=%h",
               name, err_q, err_cnt, exp_q, exp_cnt);
    end
  endtask

  // One clocked step: drive, check combinational outputs, clock, check monitor.
  task automatic step(input string name, input logic [7:0] a, input logic [7:0] b,
                      input logic c, input logic [18:0] exp);
    A = a; B = b; cin = c;
    #1;
    check_comb(name, exp);
    @(posedge clk);
    if (!rst_n) begin
      exp_q = 1'b0; exp_cnt = '0;
    end else begin
      exp_q = exp[0];
      if (exp[0] && exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
    end
    #1;
    check_seq({name, "_seq"});
  endtask

  initial begin
    tbl[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'hF0, 1'b0, 1'b1};
    tbl[2] = '{8'h88, 8'h88, 1'b0, 8'h10, 1'b1, 8'h10, 1'b1, 1'b0};
    tbl[3] = '{8'h07, 8'h08, 1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 8'h01, 1'b0, 1'b0};
    tbl[5] = '{8'h0F, 8'h0F, 1'b0, 8'h1E, 1'b0, 8'h1E, 1'b0, 1'b0};
    tbl[6] = '{8'hF8, 8'h08, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[7] = '{8'h7F, 8'h80, 1'b1, 8'h00, 1'b1, 8'hF0, 1'b0, 1'b1};

    rst_n = 1'b0; A = 8'h0F; B = 8'h01; cin = 1'b0;
    exp_q = 1'b0; exp_cnt = '0;

    // Reset state after one edge with a miss on the inputs.
    @(posedge clk); #1;
    check_seq("reset_state");

    // Exhaustive sweep with reset held; combinational outputs must not care.
    for (int c = 0; c < 2; c++) begin
      for (int a = 0; a < 256; a++) begin
        for (int b = 0; b < 256; b++) begin
          A = 8'(a); B = 8'(b); cin = 1'(c);
          #1;
          check_comb("sweep", model(A, B, cin));
        end
      end
    end

    @(negedge clk);
    rst_n = 1'b1;

    // Directed table; expectations are hand-derived constants.
    for (int i = 0; i < 8; i++) begin
      step($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].c,
           {tbl[i].e_cout, tbl[i].e_sum, tbl[i].e_acout, tbl[i].e_asum, tbl[i].e_err});
    end

    // Randomized run against the arithmetic model.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rc;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      step("rand", ra, rb, rc, model(ra, rb, rc));
    end

    // Force a known miss, then reset mid-run with the miss still present.
    step("pre_rst", 8'h0F, 8'h01, 1'b0, model(8'h0F, 8'h01, 1'b0));
    rst_n = 1'b0;
    step("mid_rst", 8'h0F, 8'h01, 1'b0, model(8'h0F, 8'h01, 1'b0));
    rst_n = 1'b1;

    // Saturation: miss held for 2^CNT_W+2 edges.
    A = 8'h0F; B = 8'h01; cin = 1'b0;
    repeat ((1 << CNT_W) + 2) @(posedge clk);
    #1;
    exp_q = 1'b1; exp_cnt = {CNT_W{1'b1}};
    check_seq("saturate");
    @(posedge clk); #1;
    check_seq("saturate_hold");

    // Counter leaves saturation only through reset.
    rst_n = 1'b0;
    step("sat_rst", 8'h0F, 8'h01, 1'b0, model(8'h0F, 8'h01, 1'b0));
    rst_n = 1'b1;
    step("post_rst_inc", 8'h07, 8'h08, 1'b1, model(8'h07, 8'h08, 1'b1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
